// File: rtl/sram_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_avalon_arbiter
// Purpose  : Shares one Avalon-MM SRAM slave port between two masters.
//            Commands are forwarded combinationally under round-robin
//            arbitration, and the grant is held while the slave stalls.
//            A tag FIFO records the owner of each outstanding read, so that
//            pipelined responses are returned, in order, to the master that
//            issued them.
// Ports    : clk, rst (async active-low)
//            m0_* / m1_*  master-side command inputs, plus waitrequest and
//                         read-response outputs
//            s_*          slave-side command outputs, plus waitrequest and
//                         read-response inputs
//            pending_count  number of outstanding reads
//            err_orphan     sticky: a response arrived with no outstanding tag
// Revision : 1.0  initial release
// ============================================================================
module sram_avalon_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 m0_read_n,
    input  logic                                 m0_write_n,
    input  logic [ADDR_W-1:0]                    m0_address,
    input  logic [DATA_W-1:0]                    m0_writeData,
    input  logic [1:0]                           m0_byteEnable_n,
    output logic                                 m0_waitrequest,
    output logic [DATA_W-1:0]                    m0_readData,
    output logic                                 m0_readdatavalid,
    input  logic                                 m1_read_n,
    input  logic                                 m1_write_n,
    input  logic [ADDR_W-1:0]                    m1_address,
    input  logic [DATA_W-1:0]                    m1_writeData,
    input  logic [1:0]                           m1_byteEnable_n,
    output logic                                 m1_waitrequest,
    output logic [DATA_W-1:0]                    m1_readData,
    output logic                                 m1_readdatavalid,
    output logic                                 s_read_n,
    output logic                                 s_write_n,
    output logic [ADDR_W-1:0]                    s_address,
    output logic [DATA_W-1:0]                    s_writeData,
    output logic [1:0]                           s_byteEnable_n,
    input  logic                                 s_waitrequest,
    input  logic [DATA_W-1:0]                    s_readData,
    input  logic                                 s_readdatavalid,
    output logic [$clog2(MAX_PENDING+1)-1:0]     pending_count,
    output logic                                 err_orphan
);

    localparam int PC_W = $clog2(MAX_PENDING + 1);

    localparam logic [1:0]      c_ST_OPEN  = 2'd0;
    localparam logic [1:0]      c_ST_LOCK0 = 2'd1;
    localparam logic [1:0]      c_ST_LOCK1 = 2'd2;
    localparam logic [PC_W-1:0] c_PEND_MAX = PC_W'(MAX_PENDING);
    localparam logic [PC_W-1:0] c_PEND_ONE = PC_W'(1);

    logic [1:0]             state_q,   state_d;
    logic                   rr_q,      rr_d;
    logic [MAX_PENDING-1:0] tag_q,     tag_d;     // bit 0 is the FIFO head
    logic [PC_W-1:0]        pending_q, pending_d;
    logic                   err_q,     err_d;

    logic            w_req0, w_req1, w_rdo0, w_rdo1, w_elig0, w_elig1;
    logic            w_fwd_valid, w_fwd_id;
    logic            w_accept, w_push, w_pop, w_orphan;
    logic [PC_W-1:0] w_wr_idx;

    // A request with both strobes low counts as a write: only read-only
    // requests consume a tag, so only they are throttled by the pending limit.
    assign w_req0  = ~m0_read_n | ~m0_write_n;
    assign w_req1  = ~m1_read_n | ~m1_write_n;
    assign w_rdo0  = ~m0_read_n & m0_write_n;
    assign w_rdo1  = ~m1_read_n & m1_write_n;
    assign w_elig0 = w_req0 & (~w_rdo0 | (pending_q < c_PEND_MAX));
    assign w_elig1 = w_req1 & (~w_rdo1 | (pending_q < c_PEND_MAX));

    // Grant selection. The rst gate keeps the slave command idle while
    // reset is held, even if a master is still requesting.
    always_comb begin
        w_fwd_valid = 1'b0;
        w_fwd_id    = 1'b0;
        if (rst) begin
            case (state_q)
                c_ST_LOCK0: begin w_fwd_valid = 1'b1; w_fwd_id = 1'b0; end
                c_ST_LOCK1: begin w_fwd_valid = 1'b1; w_fwd_id = 1'b1; end
                default: begin
                    w_fwd_valid = w_elig0 | w_elig1;
                    if (w_elig0 && w_elig1) w_fwd_id = rr_q;
                    else                    w_fwd_id = w_elig1;
                end
            endcase
        end
    end

    assign w_accept = w_fwd_valid & ~s_waitrequest;
    assign w_push   = w_accept & (w_fwd_id ? w_rdo1 : w_rdo0);
    assign w_pop    = s_readdatavalid & (pending_q != '0);
    assign w_orphan = s_readdatavalid & (pending_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= c_ST_OPEN;
            rr_q      <= 1'b0;
            tag_q     <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            tag_q     <= tag_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        tag_d     = tag_q;
        pending_d = pending_q;
        err_d     = err_q | w_orphan;
        w_wr_idx  = pending_q;

        case (state_q)
            c_ST_OPEN: begin
                if (w_fwd_valid && s_waitrequest)
                    state_d = w_fwd_id ? c_ST_LOCK1 : c_ST_LOCK0;
            end
            c_ST_LOCK0, c_ST_LOCK1: begin
                if (!s_waitrequest) state_d = c_ST_OPEN;
            end
            default: state_d = c_ST_OPEN;
        endcase

        if (w_accept) rr_d = ~w_fwd_id;

        case ({w_push, w_pop})
            2'b10:   pending_d = pending_q + c_PEND_ONE;
            2'b01:   pending_d = pending_q - c_PEND_ONE;
            default: pending_d = pending_q;
        endcase

        // Pop shifts the queue toward bit 0; a push lands just behind the
        // last surviving entry, which is one slot lower when popping too.
        if (w_pop) begin
            tag_d    = tag_q >> 1;
            w_wr_idx = pending_q - c_PEND_ONE;
        end
        for (int i = 0; i < MAX_PENDING; i++) begin
            if (w_push && (PC_W'(i) == w_wr_idx)) tag_d[i] = w_fwd_id;
        end
    end

    // Output logic
    always_comb begin
        s_read_n         = 1'b1;
        s_write_n        = 1'b1;
        s_address        = '0;
        s_writeData      = '0;
        s_byteEnable_n   = 2'b11;
        m0_waitrequest   = w_req0;
        m1_waitrequest   = w_req1;
        if (w_fwd_valid) begin
            if (w_fwd_id) begin
                s_read_n       = m1_read_n;
                s_write_n      = m1_write_n;
                s_address      = m1_address;
                s_writeData    = m1_writeData;
                s_byteEnable_n = m1_byteEnable_n;
                m1_waitrequest = s_waitrequest;
            end else begin
                s_read_n       = m0_read_n;
                s_write_n      = m0_write_n;
                s_address      = m0_address;
                s_writeData    = m0_writeData;
                s_byteEnable_n = m0_byteEnable_n;
                m0_waitrequest = s_waitrequest;
            end
        end
        m0_readdatavalid = w_pop & ~tag_q[0];
        m1_readdatavalid = w_pop &  tag_q[0];
        m0_readData      = m0_readdatavalid ? s_readData : '0;
        m1_readData      = m1_readdatavalid ? s_readData : '0;
    end

    assign pending_count = pending_q;
    assign err_orphan    = err_q;

endmodule
`default_nettype wire
